// File: rtl/esm_pkg.sv
// esm_pkg: shared constants and slot-state record for the dependency scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package esm_pkg;

    localparam int BS_DEF      = 16;
    localparam int BS_BITS_DEF = $clog2(BS_DEF);

    // Per-slot scheduling state. The row is sized for the default slot count;
    // smaller builds leave the upper row bits at zero.
    typedef struct packed {
        logic              valid;
        logic              issued;
        logic [BS_DEF-1:0] row;
    } slot_t;

endpackage

// File: rtl/dep_sched_if.sv
// dep_sched_if: allocation, completion, issue handshake and status bundle of dep_sched.
// Latency: n/a (wiring only).
// Backpressure: issue_valid/issue_ready handshake; alloc and done are unconditional pulses.
interface dep_sched_if #(
    parameter int BS = esm_pkg::BS_DEF
);
    localparam int BS_BITS = $clog2(BS);

    logic               alloc_valid;
    logic [BS_BITS-1:0] alloc_idx;
    logic [BS-1:0]      alloc_dep;
    logic               done_valid;
    logic [BS_BITS-1:0] done_idx;
    logic               issue_valid;
    logic [BS_BITS-1:0] issue_idx;
    logic               issue_ready;
    logic [BS-1:0]      occupied;
    logic               alloc_err;

    // Environment side: allocates, completes and consumes offers.
    modport master (
        output alloc_valid, alloc_idx, alloc_dep, done_valid, done_idx, issue_ready,
        input  issue_valid, issue_idx, occupied, alloc_err
    );

    // Scheduler side.
    modport slave (
        input  alloc_valid, alloc_idx, alloc_dep, done_valid, done_idx, issue_ready,
        output issue_valid, issue_idx, occupied, alloc_err
    );
endinterface

// File: rtl/dep_sched_pick.sv
// dep_sched_pick: chooses one ready slot (oldest when DEP_SCHED_AGE_EN is defined, else lowest index).
// Latency: combinational.
// Backpressure: none; the caller decides when to register the grant.
module dep_sched_pick
    import esm_pkg::*;
#(
    parameter int BS = BS_DEF
) (
    input  logic [BS-1:0]         ready,
`ifdef DEP_SCHED_AGE_EN
    input  logic [BS-1:0]         age [BS],   // age[i][j]: slot i is older than slot j
`endif
    output logic [BS-1:0]         grant,
    output logic [$clog2(BS)-1:0] idx
);
    localparam int BS_BITS = $clog2(BS);

    logic [BS-1:0] cand;

`ifdef DEP_SCHED_AGE_EN
    // A ready slot is a candidate only if no other ready slot is older than it.
    always_comb begin
        cand = '0;
        for (int i = 0; i < BS; i++) begin
            cand[i] = ready[i];
            for (int j = 0; j < BS; j++) begin
                if (j != i && ready[j] && age[j][i]) begin
                    cand[i] = 1'b0;
                end
            end
        end
    end
`else
    assign cand = ready;
`endif

    // Lowest set candidate bit; also breaks any tie the age matrix leaves.
    assign grant = cand & (~cand + BS'(1));

    // Encode the one-hot grant.
    always_comb begin
        idx = '0;
        for (int i = 0; i < BS; i++) begin
            if (grant[i]) begin
                idx = idx | BS_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/dep_sched.sv
// dep_sched: dependency-matrix scheduler over BS slots; optional oldest-first pick via DEP_SCHED_AGE_EN.
// Latency: slot ready after edge N is offered after edge N+1; one idle cycle follows every accept.
// Backpressure: offer held stable until issue_ready; only a completion of the offered slot withdraws it.
module dep_sched
    import esm_pkg::*;
#(
    parameter int BS = BS_DEF
) (
    input logic        clk,
    input logic        rst_n,
    dep_sched_if.slave bus
);
    localparam int BS_BITS = $clog2(BS);

    slot_t              slot_q [BS];
    logic [BS-1:0]      occ;
    logic [BS-1:0]      ready;
    logic [BS-1:0]      grant;
    logic [BS-1:0]      done_mask;
    logic [BS-1:0]      alloc_row;
    logic [BS_BITS-1:0] pick_idx;
    logic               issue_valid_q;
    logic [BS_BITS-1:0] issue_idx_q;
    logic               alloc_err_q;
    logic               accept;
    logic               done_on_offer;

    // Occupancy and readiness come straight from registered slot state.
    always_comb begin
        occ   = '0;
        ready = '0;
        for (int i = 0; i < BS; i++) begin
            occ[i]   = slot_q[i].valid;
            ready[i] = slot_q[i].valid & ~slot_q[i].issued & (slot_q[i].row == '0);
        end
    end

    // A completing slot is never recorded as a dependency of a same-cycle allocation.
    assign done_mask     = bus.done_valid ? (BS'(1) << bus.done_idx) : '0;
    assign alloc_row     = bus.alloc_dep & occ & ~(BS'(1) << bus.alloc_idx) & ~done_mask;
    assign accept        = issue_valid_q & bus.issue_ready;
    assign done_on_offer = issue_valid_q & bus.done_valid & (bus.done_idx == issue_idx_q);

    // Slot update, applied in priority order issue < done < alloc so a same-slot alloc wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BS; i++) begin
                if (accept && issue_idx_q == BS_BITS'(i)) begin
                    slot_q[i].issued <= 1'b1;
                end
                if (bus.done_valid) begin
                    slot_q[i].row[bus.done_idx] <= 1'b0;
                end
                if (bus.done_valid && bus.done_idx == BS_BITS'(i)) begin
                    slot_q[i].valid  <= 1'b0;
                    slot_q[i].issued <= 1'b0;
                end
                if (bus.alloc_valid && bus.alloc_idx == BS_BITS'(i)) begin
                    slot_q[i].valid  <= 1'b1;
                    slot_q[i].issued <= 1'b0;
                    slot_q[i].row    <= BS_DEF'(alloc_row);
                end
            end
        end
    end

`ifdef DEP_SCHED_AGE_EN
    logic [BS-1:0] age_q [BS];

    // New slot is younger than every slot still occupied after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BS; i++) begin
                age_q[i] <= '0;
            end
        end else if (bus.alloc_valid) begin
            for (int i = 0; i < BS; i++) begin
                if (bus.alloc_idx == BS_BITS'(i)) begin
                    age_q[i] <= '0;
                end else begin
                    age_q[i][bus.alloc_idx] <= occ[i] & ~done_mask[i];
                end
            end
        end
    end
`endif

    dep_sched_pick #(.BS(BS)) u_pick (
        .ready (ready),
`ifdef DEP_SCHED_AGE_EN
        .age   (age_q),
`endif
        .grant (grant),
        .idx   (pick_idx)
    );

    // Registered offer: hold until accepted or completed, then idle one cycle before re-picking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
        end else if (issue_valid_q) begin
            if (accept || done_on_offer) begin
                issue_valid_q <= 1'b0;
            end
        end else if (|grant) begin
            issue_valid_q <= 1'b1;
            issue_idx_q   <= pick_idx;
        end
    end

    // Sticky error: allocation landed on a slot that is not completing this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_err_q <= 1'b0;
        end else if (bus.alloc_valid && occ[bus.alloc_idx] &&
                     !(bus.done_valid && bus.done_idx == bus.alloc_idx)) begin
            alloc_err_q <= 1'b1;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_idx   = issue_idx_q;
    assign bus.occupied    = occ;
    assign bus.alloc_err   = alloc_err_q;

endmodule

// File: doc/dep_sched.md
DEP_SCHED -- requirements
Module: dep_sched

Interface
REQ-001 SHALL have parameter BS, default 16, meaning number of instruction buffer slots (power of two, ≥2).
REQ-002 SHALL have localparam BS_BITS = $clog2(BS), meaning slot index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port alloc_valid  input  1  a new instruction enters slot alloc_idx this cycle.
REQ-006 SHALL have port alloc_idx  input  BS_BITS  slot receiving the new instruction.
REQ-007 SHALL have port alloc_dep  input  BS  dependency vector for the new instruction; bit k set means "waits on slot k".
REQ-008 SHALL have port done_valid  input  1  an issued instruction completed this cycle.
REQ-009 SHALL have port done_idx  input  BS_BITS  slot that completed.
REQ-010 SHALL have port issue_valid  output  1  a ready instruction is offered.
REQ-011 SHALL have port issue_idx  output  BS_BITS  slot offered.
REQ-012 SHALL have port issue_ready  input  1  downstream accepts the offer.
REQ-013 SHALL have port occupied  output  BS  per-slot valid flags.
REQ-014 SHALL have port alloc_err  output  1  sticky flag: allocation hit an occupied slot.

Function
REQ-015 SHALL hold per slot: valid bit, issued bit, BS-bit dependency row.
REQ-016 On alloc, SHALL write row[alloc_idx] = alloc_dep & occupied & ~(1<<alloc_idx) & ~done column mask; set valid, clear issued.
REQ-017 On done, SHALL clear valid and issued of done_idx and clear column done_idx in every row, same edge.
REQ-018 Slot is ready when valid & ~issued & row == 0, evaluated on registered state.
REQ-019 issue_valid/issue_idx SHALL be registered: a slot ready after edge N is offered no earlier than after edge N+1.
REQ-020 Once issue_valid is high, issue_idx SHALL stay stable until issue_ready is sampled high (no retraction).
REQ-021 On issue_valid & issue_ready, SHALL set issued[issue_idx]; next offer earliest the following cycle.
REQ-022 Without age selection, SHALL pick the lowest-index ready slot.
REQ-023 Simultaneous alloc and done on the same index: done applies first, then alloc; slot ends valid with new row.
REQ-024 Done on a slot already invalid SHALL be ignored, except column clear still applies.
REQ-025 Alloc to an occupied slot (not completing the same cycle) SHALL overwrite it and set alloc_err until reset.
REQ-026 Done on the slot currently offered SHALL drop issue_valid the next cycle.

Reset
REQ-027 While rst_n low: all valid, issued, row bits = 0; issue_valid = 0; issue_idx = 0; occupied = 0; alloc_err = 0.
REQ-028 Reset assertion mid-offer SHALL drop issue_valid immediately (asynchronously); no handshake completes.

Configuration
REQ-029 Macro DEP_SCHED_AGE_EN: when defined, SHALL keep a BS×BS age matrix (set on alloc: new slot younger than all occupied) and pick the oldest ready slot; when undefined, no age state, lowest-index pick (REQ-022).

Structure
REQ-030 BS and BS_BITS defaults, and the slot-state struct (valid, issued, row), SHALL live in shared package esm_pkg.
REQ-031 Selection SHALL be a sub-module dep_sched_pick (ready vector, optional age matrix in; one-hot grant plus index out).

Verification
REQ-032 Reset, then alloc slot 3 with dep 0 → issue_valid = 1, issue_idx = 3 two edges after alloc.
REQ-033 Alloc slot 2 dep 0, slot 5 dep 0x0004; issue_ready = 1 → slot 2 issued; done_idx = 2 → slot 5 offered next cycle.
REQ-034 issue_ready = 0 for 4 cycles while slot 7 ready, then slot 1 becomes ready → issue_idx stays 7 until accepted.
REQ-035 alloc and done both on slot 4 in same cycle, alloc_dep = 0x0010 → slot 4 valid, row 0, offered next.
REQ-036 Alloc slot 6 while occupied → alloc_err = 1, row replaced; alloc_err remains 1 until rst_n low.
REQ-037 With DEP_SCHED_AGE_EN: alloc slot 9 then slot 1, both ready → issue_idx = 9; without macro → 1.
